// File: rtl/fix_to_float_if.sv
// ============================================================================
// Module      : fix_to_float_if
// Description : Start/done handshake and data bundle for fix_to_float.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fix_to_float_if;
    logic        start;
    logic [4:0]  fixpointpos;
    logic [31:0] fixnumber;
    logic        busy;
    logic        done;
    logic [31:0] result;

    modport master (
        output start,
        output fixpointpos,
        output fixnumber,
        input  busy,
        input  done,
        input  result
    );

    modport slave (
        input  start,
        input  fixpointpos,
        input  fixnumber,
        output busy,
        output done,
        output result
    );
endinterface

`default_nettype wire

// File: rtl/fix_to_float.sv
// ============================================================================
// Module      : fix_to_float
// Description : Signed fixed-point to IEEE-754 single converter, one-bit-per-
//               cycle normalization, truncating mantissa.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fix_to_float (
    input  wire logic     clk,
    input  wire logic     rst,
    fix_to_float_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        PACK = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    logic        sign;
    logic [31:0] mag;
    logic [4:0]  k;
    logic [4:0]  fp;
    logic        zero;
    logic        done_q;
    logic [31:0] result_q;

    logic [31:0] abs_in;
    logic [8:0]  exp_w;
    logic        unused_bits;

    // Two's-complement negate; 0x80000000 maps onto itself, read as unsigned.
    assign abs_in = bus.fixnumber[31] ? (~bus.fixnumber + 32'd1) : bus.fixnumber;
    assign exp_w  = 9'd158 - {4'd0, k} - {4'd0, fp};

    // Truncated mantissa bits and the always-zero exponent MSB are dropped.
    assign unused_bits = ^{mag[7:0], exp_w[8]};

    assign bus.busy   = (state != IDLE) || done_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Zero input still passes through NORM so its latency matches k=0 (two cycles).
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (bus.start)          state_next = NORM;
            NORM: if (mag[31] || zero)    state_next = PACK;
            PACK:                         state_next = IDLE;
            default:                      state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sign     <= 1'b0;
            mag      <= 32'd0;
            k        <= 5'd0;
            fp       <= 5'd0;
            zero     <= 1'b0;
            done_q   <= 1'b0;
            result_q <= 32'd0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        sign <= bus.fixnumber[31];
                        mag  <= abs_in;
                        fp   <= bus.fixpointpos;
                        k    <= 5'd0;
                        zero <= (bus.fixnumber == 32'd0);
                    end
                end
                NORM: begin
                    if (!mag[31] && !zero) begin
                        mag <= mag << 1;
                        k   <= k + 5'd1;
                    end
                end
                PACK: begin
                    result_q <= zero ? 32'd0 : {sign, exp_w[7:0], mag[30:8]};
                    done_q   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire
